johnson_seq_checker: RTL
========================

// Module: johnson_seq_checker
// PURPOSE
//  Receive-side companion to the 4-bit Johnson (twisted-ring) counters: samples a Johnson code
//  bus, decodes it to a binary phase index, checks that every sampled code is legal and the exact
//  successor of the previous one, and counts full rotations. Sits downstream of a Johnson counter
//  or a Johnson-coded link as a decoder plus health monitor.
// PARAMETERS
//  N     4  Johnson code width in bits; 2N legal codes; N >= 2
//  W_ROT 8  width of rotation counter rot_cnt
//  W_ERR 8  width of saturating error counter err_cnt
// PORTS
//  clk      in   1            clock, all state updates on posedge
//  clr      in   1            synchronous active-high reset, priority over everything
//  stb      in   1            sample strobe: d is sampled on this edge, source has advanced one step
//  d        in   N            Johnson code from source counter
//  idx      out  clog2(2N)    decoded phase index of last legal sample (registered)
//  valid    out  1            1-cycle pulse: idx updated from a legal sample
//  tc       out  1            registered: last legal sample was all-ones (idx == N)
//  wrap     out  1            1-cycle pulse: legal step from idx 2N-1 to idx 0 while LOCKED
//  lock     out  1            state == LOCKED
//  illegal  out  1            1-cycle pulse: sampled code not one of the 2N legal codes
//  skip     out  1            1-cycle pulse: legal code but not the successor of the previous sample
//  rot_cnt  out  W_ROT        count of wrap events, modulo 2^W_ROT
//  err_cnt  out  W_ERR        count of illegal + skip events, saturates at all-ones
// BEHAVIOUR
//  Sequence, LSB-fed with inverted MSB: 0000,0001,0011,0111,1111,1110,1100,1000, back to 0000.
//  Legal iff d[N-1]=0 and d = 0..01..1 (ones contiguous from bit 0, incl. all-zero), or
//    d[N-1]=1 and d = 1..10..0 (ones contiguous from MSB, incl. all-ones).
//  Decode: k = popcount(d); idx = k if d[N-1]=0, else 2N-k. Successor of i is (i+1) mod 2N.
//  Latency: every output reflects the sample taken on the previous stb edge (1 clk).
//  stb=0: no state change; idx, tc, lock, counters hold; all pulses 0.
//  States: SEARCH (reset), LOCKED. Registered last index last_idx.
//  SEARCH, stb, legal      -> LOCKED; idx=last_idx=decode(d); valid=1; no skip, no wrap.
//  SEARCH, stb, illegal    -> stay SEARCH; illegal=1; err_cnt+1; idx holds.
//  LOCKED, stb, successor  -> stay LOCKED; idx updated; valid=1; wrap=1 and rot_cnt+1 if 2N-1 -> 0.
//  LOCKED, stb, legal non-successor (incl. repeat of same code) -> stay LOCKED, resync:
//    idx=last_idx=decode(d); valid=1; skip=1; err_cnt+1; no wrap even if new idx is 0.
//  LOCKED, stb, illegal    -> SEARCH; illegal=1; err_cnt+1; idx and tc hold.
//  tc updates only with valid; holds otherwise.
//  illegal and skip are mutually exclusive; err_cnt increments by 1 per event, sticks at max.
//  rot_cnt wraps to 0 after 2^W_ROT-1 with no flag.
//  clr=1 (any state, any stb): next edge idx=0, last_idx=0, tc=0, lock=0, all pulses 0,
//    rot_cnt=0, err_cnt=0, state SEARCH. Same values at power-up.
// TESTING
//  1 clr then stb with d=0000 -> next cycle lock=1, idx=0, valid=1, tc=0, err_cnt=0.
//  2 lock at 0000, stb each cycle through 0001..1000,0000 -> idx 1..7,0; tc=1 only after 1111;
//    wrap=1 exactly on 1000->0000; rot_cnt=1; skip/illegal never asserted.
//  3 locked at 0001, stb d=0111 -> skip=1, idx=3, lock=1, err_cnt=1; then 1111 -> valid, no skip.
//  4 locked, stb d=0010 (preset-2 value, illegal) -> illegal=1, lock=0, idx holds; then d=0011
//    -> lock=1, idx=2, no skip pulse.
//  5 stb=0 for 10 cycles with d toggling randomly -> no output change, no pulses.
//  6 clr asserted mid-sequence with stb=1, d illegal -> clr wins: all outputs reset, no illegal
//    pulse, err_cnt=0; 2^W_ERR+3 illegal samples -> err_cnt stuck at all-ones.

Source files
------------

// File: rtl/johnson_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : johnson_seq_checker
// Description : Samples an N-bit Johnson code bus on each strobe, decodes it
//               to a phase index, flags illegal codes and out-of-order steps,
//               counts full rotations and saturating errors.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_seq_checker #(
  parameter int N     = 4,
  parameter int W_ROT = 8,
  parameter int W_ERR = 8
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     stb_i,
  input  logic [N-1:0]             d_i,
  output logic [$clog2(2*N)-1:0]   idx_o,
  output logic                     valid_o,
  output logic                     tc_o,
  output logic                     wrap_o,
  output logic                     lock_o,
  output logic                     illegal_o,
  output logic                     skip_o,
  output logic [W_ROT-1:0]         rot_cnt_o,
  output logic [W_ERR-1:0]         err_cnt_o
);

  localparam int              IW       = $clog2(2*N);
  // 2N taken modulo 2^IW; when 2N is a power of two this is zero and the
  // subtraction in the decoder still wraps to the right value.
  localparam logic [IW-1:0]   TWO_N    = IW'(2*N);
  localparam logic [IW-1:0]   LAST_IDX = IW'(2*N-1);
  localparam logic [IW-1:0]   TC_IDX   = IW'(N);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [N-1:0]    D_ONE    = N'(1);
  localparam logic [W_ROT-1:0] ROT_ONE = W_ROT'(1);
  localparam logic [W_ERR-1:0] ERR_ONE = W_ERR'(1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  // idx_q doubles as the last legal index used for successor checking.
  logic [IW-1:0]    idx_q, idx_d;
  logic             tc_q, tc_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;
  logic             skip_q, skip_d;
  logic [W_ROT-1:0] rot_q, rot_d;
  logic [W_ERR-1:0] err_q, err_d;

  logic [N-1:0]     w_low;
  logic             w_legal;
  logic [IW-1:0]    w_pop;
  logic [IW-1:0]    w_dec;
  logic [IW-1:0]    w_succ;
  logic [W_ERR-1:0] w_err_inc;

  // Legality: codes with MSB=0 must be 0..01..1; codes with MSB=1 must be
  // 1..10..0, i.e. their complement is 0..01..1. A low mask m satisfies m&(m+1)==0.
  always_comb begin
    w_low   = d_i[N-1] ? ~d_i : d_i;
    w_legal = ((w_low & (w_low + D_ONE)) == '0);
  end

  // Popcount decode to phase index, plus successor of the last index.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + {{(IW-1){1'b0}}, d_i[i]};
    end
    w_dec     = d_i[N-1] ? (TWO_N - w_pop) : w_pop;
    w_succ    = (idx_q == LAST_IDX) ? '0 : (idx_q + IDX_ONE);
    w_err_inc = (&err_q) ? err_q : (err_q + ERR_ONE);
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tc_d      = tc_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    skip_d    = 1'b0;
    rot_d     = rot_q;
    err_d     = err_q;
    if (stb_i) begin
      if (!w_legal) begin
        state_d   = SEARCH;
        illegal_d = 1'b1;
        err_d     = w_err_inc;
      end else begin
        idx_d   = w_dec;
        tc_d    = (w_dec == TC_IDX);
        valid_d = 1'b1;
        if (state_q == SEARCH) begin
          state_d = LOCKED;
        end else if (w_dec == w_succ) begin
          if (idx_q == LAST_IDX) begin
            wrap_d = 1'b1;
            rot_d  = rot_q + ROT_ONE;
          end
        end else begin
          // Legal but out of order: resynchronise to the new phase.
          skip_d = 1'b1;
          err_d  = w_err_inc;
        end
      end
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      state_q   <= SEARCH;
      idx_q     <= '0;
      tc_q      <= 1'b0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
      skip_q    <= 1'b0;
      rot_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tc_q      <= tc_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      illegal_q <= illegal_d;
      skip_q    <= skip_d;
      rot_q     <= rot_d;
      err_q     <= err_d;
    end
  end

  assign idx_o     = idx_q;
  assign valid_o   = valid_q;
  assign tc_o      = tc_q;
  assign wrap_o    = wrap_q;
  assign lock_o    = (state_q == LOCKED);
  assign illegal_o = illegal_q;
  assign skip_o    = skip_q;
  assign rot_cnt_o = rot_q;
  assign err_cnt_o = err_q;

endmodule
`default_nettype wire
